// File: rtl/proc_pkg.sv
// Shared types for the instruction-fetch path.
// State encoding and default widths.
package proc_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_DONE,
        ADVANCE,
        HALT
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector for pushbutton-style inputs.
// rise is high for the first cycle that d is seen high.
module edge_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember the previous level of d.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer between a synchronous ROM and the core.
// Waits out read latency, then hands the word over with Run/Done.
module fetch_sequencer
    import proc_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_LATENCY = 1,
    parameter int LAST_ADDR   = 2**ADDR_W - 1,
    parameter int WRAP        = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Step,
    input  logic              Auto,
    input  logic              LoadAddr,
    input  logic [ADDR_W-1:0] LoadValue,
    input  logic [DATA_W-1:0] MemData,
    input  logic              Done,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Instr,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic [15:0]       InstrCount
);

    localparam int LAT_W = 3;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              run_q, run_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              step_go;

    // Step is edge-qualified everywhere so a held button fetches once.
    edge_detect u_step_edge (
        .Clock (Clock),
        .Reset (Reset),
        .d     (Step),
        .rise  (step_go)
    );

    // State and datapath registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            instr_q <= '0;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state, address, capture and handshake logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (LoadAddr) begin
                    addr_d = LoadValue;
                end else if (step_go || Auto) begin
                    state_d = FETCH;
                    lat_d   = '0;
                end
            end
            FETCH: begin
                if (lat_q == LAT_LAST) begin
                    instr_d = MemData;
                    state_d = ISSUE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ISSUE: begin
                run_d   = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (Done) begin
                    run_d   = 1'b0;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (addr_q != LAST) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = IDLE;
                end else if (WRAP != 0) begin
                    addr_d  = '0;
                    state_d = IDLE;
                end else begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (LoadAddr) begin
                    addr_d  = LoadValue;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Addr       = addr_q;
    assign Instr      = instr_q;
    assign Run        = run_q;
    assign InstrCount = cnt_q;
    assign Busy       = (state_q != IDLE) && (state_q != HALT);
    assign Halted     = (state_q == HALT);

endmodule
